// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master)
// and instruction memory (slave): one request, one grant, one read beat.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with branch/jump/flush redirect.
// Optional FETCH_ILLEGAL_TRAP_EN: unsupported opcodes set illegal_op and halt until reset.
//
// state | meaning
// IDLE  | one cycle after reset, then request
// REQ   | imem_req high, waiting for grant
// WAIT  | granted, waiting for rvalid (kill = drop this response)
// HOLD  | instruction presented to decode until id_ready or flush
// HALT  | unsupported opcode captured, only rst leaves (trap build only)
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_unit_if.master         imem,
  input  logic                       id_ready,
  input  logic                       branch_taken,
  input  logic [63:0]                branch_target,
  input  logic                       jump,
  input  logic [63:0]                jump_target,
  input  logic                       flush,
  input  logic [63:0]                flush_pc,
  output logic [31:0]                instr,
  output logic [6:0]                 opcode,
  output logic [63:0]                pc_out,
  output logic                       instr_valid,
  output logic                       illegal_op
);

  localparam logic [63:0] ALIGN_MASK = ~64'h3;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

`ifdef FETCH_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state;
  logic [63:0] pc;
  logic [63:0] next_pc;
  logic [63:0] flush_addr;
  logic        kill;
  logic        req_q;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;
  assign opcode         = instr[6:0];
  assign flush_addr     = flush_pc & ALIGN_MASK;

  always_comb begin
    next_pc = pc + 64'd4;
    if (jump)
      next_pc = jump_target & ALIGN_MASK;
    else if (branch_taken)
      next_pc = branch_target & ALIGN_MASK;
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b0000011, 7'b0100011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  logic illegal_q;
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
      kill        <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) pc <= flush_addr;
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          // A flush coinciding with a grant cannot retract the accepted address,
          // so the response it produces is marked for discard instead.
          if (imem.imem_gnt) begin
            state <= S_WAIT;
            req_q <= 1'b0;
            if (flush) begin
              pc   <= flush_addr;
              kill <= 1'b1;
            end
          end else if (flush) begin
            pc <= flush_addr;
          end
        end
        S_WAIT: begin
          if (flush) begin
            pc <= flush_addr;
            if (imem.imem_rvalid) begin
              kill  <= 1'b0;
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem.imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              instr  <= imem.imem_rdata;
              pc_out <= pc;
`ifdef FETCH_ILLEGAL_TRAP_EN
              if (!opcode_legal(imem.imem_rdata[6:0])) begin
                illegal_q <= 1'b1;
                state     <= S_HALT;
              end else
`endif
              begin
                instr_valid <= 1'b1;
                state       <= S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (flush) begin
            pc          <= flush_addr;
            instr_valid <= 1'b0;
            state       <= S_REQ;
            req_q       <= 1'b1;
          end else if (id_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= S_REQ;
            req_q       <= 1'b1;
          end
        end
`ifdef FETCH_ILLEGAL_TRAP_EN
        S_HALT: begin
          state <= S_HALT;
        end
`endif
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall, redirects,
// flush in each state, PC wrap, opcode trap (FETCH_ILLEGAL_TRAP_EN aware) and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        jump;
  logic [63:0] jump_target;
  logic        flush;
  logic [63:0] flush_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus),
    .id_ready      (id_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .instr         (instr),
    .opcode        (opcode),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in REQ, ends in HOLD with the word presented to decode.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] word);
    check("req_asserted", imem_bus.imem_req, 1);
    check("req_addr", imem_bus.imem_addr, addr);
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    check("req_dropped_wait", imem_bus.imem_req, 0);
    check("valid_low_wait", instr_valid, 0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = word;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("hold_valid", instr_valid, 1);
    check("hold_instr", instr, word);
    check("hold_pc_out", pc_out, addr);
    check("hold_opcode", opcode, word[6:0]);
    check("hold_req_low", imem_bus.imem_req, 0);
  endtask

  task automatic release_hold();
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("valid_after_release", instr_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    id_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    jump = 1'b0;
    jump_target = '0;
    flush = 1'b0;
    flush_pc = '0;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = '0;

    step();
    step();
    check("rst_req", imem_bus.imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 64'h13);
    check("rst_pc_out", pc_out, 64'h0);
    check("rst_addr", imem_bus.imem_addr, 64'h0);
    check("rst_illegal", illegal_op, 0);

    rst = 1'b0;
    step();

    // back-to-back sequential fetches, 3 cycles each
    do_fetch(64'h0, 32'h0000_0033);
    release_hold();
    do_fetch(64'h4, 32'h0050_0093);
    release_hold();
    do_fetch(64'h8, 32'h0000_0063);

    // decode stall keeps everything stable
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_instr", instr, 64'h0000_0063);
      check("stall_pc_out", pc_out, 64'h8);
      check("stall_req", imem_bus.imem_req, 0);
      check("stall_valid", instr_valid, 1);
    end
    release_hold();
    do_fetch(64'hC, 32'h0000_2003);
    release_hold();
    do_fetch(64'h10, 32'h0000_006F);

    // jump beats branch
    jump = 1'b1;
    jump_target = 64'h100;
    branch_taken = 1'b1;
    branch_target = 64'h200;
    release_hold();
    jump = 1'b0;
    branch_taken = 1'b0;
    check("jump_prio_addr", imem_bus.imem_addr, 64'h100);

    // branch target with low bits set is word-aligned
    do_fetch(64'h100, 32'h0000_2023);
    branch_taken = 1'b1;
    branch_target = 64'h207;
    release_hold();
    branch_taken = 1'b0;
    check("branch_align_addr", imem_bus.imem_addr, 64'h204);

    // flush in WAIT with same-cycle rvalid: word dropped
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    flush = 1'b1;
    flush_pc = 64'h40;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0033;
    step();
    flush = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    check("wflush_valid", instr_valid, 0);
    check("wflush_req", imem_bus.imem_req, 1);
    check("wflush_addr", imem_bus.imem_addr, 64'h40);

    // flush in WAIT before rvalid: late response killed
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    flush = 1'b1;
    flush_pc = 64'h80;
    step();
    flush = 1'b0;
    check("kill_wait_req", imem_bus.imem_req, 0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0033;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("kill_valid", instr_valid, 0);
    check("kill_req", imem_bus.imem_req, 1);
    check("kill_addr", imem_bus.imem_addr, 64'h80);

    // flush in HOLD overrides jump and id_ready
    do_fetch(64'h80, 32'h0000_0013);
    flush = 1'b1;
    flush_pc = 64'h300;
    jump = 1'b1;
    jump_target = 64'h500;
    release_hold();
    flush = 1'b0;
    jump = 1'b0;
    check("hflush_addr", imem_bus.imem_addr, 64'h300);
    check("hflush_req", imem_bus.imem_req, 1);

    // flush in REQ without grant, then sequential wrap at top of address space
    flush = 1'b1;
    flush_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    flush = 1'b0;
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0033);
    release_hold();
    check("wrap_addr", imem_bus.imem_addr, 64'h0);

    // unsupported opcode 0x7F
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0000_007F;
    step();
    imem_bus.imem_rvalid = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
    check("trap_illegal", illegal_op, 1);
    check("trap_valid", instr_valid, 0);
    check("trap_req", imem_bus.imem_req, 0);
    flush = 1'b1;
    flush_pc = 64'h40;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_req", imem_bus.imem_req, 0);
      check("halt_illegal", illegal_op, 1);
      check("halt_valid", instr_valid, 0);
    end
    flush = 1'b0;
    id_ready = 1'b0;
`else
    check("pass_valid", instr_valid, 1);
    check("pass_opcode", opcode, 64'h7F);
    check("pass_illegal", illegal_op, 0);
    release_hold();
    imem_bus.imem_gnt = 1'b1;
    step();
    imem_bus.imem_gnt = 1'b0;
`endif

    // reset with a response outstanding; late rvalid ignored
    rst = 1'b1;
    step();
    check("mrst_req", imem_bus.imem_req, 0);
    check("mrst_valid", instr_valid, 0);
    check("mrst_illegal", illegal_op, 0);
    check("mrst_pc_out", pc_out, 64'h0);
    rst = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0033;
    step();
    imem_bus.imem_rvalid = 1'b0;
    check("late_rvalid_valid", instr_valid, 0);
    check("late_rvalid_instr", instr, 64'h13);
    check("late_rvalid_req", imem_bus.imem_req, 1);
    check("late_rvalid_addr", imem_bus.imem_addr, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
